// File: rtl/mem_pkg.sv
// Shared constants and bus field layout for the asynchronous-response MEM stage.
package mem_pkg;

    localparam int LOAD_OP_W = 7;

    localparam int LD_B  = 0;
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;
    localparam int LD_WU = 5;
    localparam int LD_D  = 6;

    // es_to_ms_bus, MSB first: {pc, alu_result, dest, gr_we, res_from_mem, mem_req, load_op, vaddr, ex}
    function automatic int es_bus_w(input int dw);      return 48 + 2 * dw;  endfunction
    function automatic int es_ex_lsb(input int dw);     return 0;            endfunction
    function automatic int es_vaddr_lsb(input int dw);  return 1;            endfunction
    function automatic int es_lop_lsb(input int dw);    return dw + 1;       endfunction
    function automatic int es_mreq_lsb(input int dw);   return dw + 8;       endfunction
    function automatic int es_rfm_lsb(input int dw);    return dw + 9;       endfunction
    function automatic int es_grwe_lsb(input int dw);   return dw + 10;      endfunction
    function automatic int es_dest_lsb(input int dw);   return dw + 11;      endfunction
    function automatic int es_alu_lsb(input int dw);    return dw + 16;      endfunction
    function automatic int es_pc_lsb(input int dw);     return 2 * dw + 16;  endfunction

    // ms_to_ws_bus, MSB first: {pc, ex, gr_we, dest, final_result}
    function automatic int ws_bus_w(input int dw);      return 39 + dw;      endfunction

    function automatic int off_w(input int dw);         return $clog2(dw / 8); endfunction

endpackage

// File: rtl/mem_stage_async_load_align.sv
// Load data lane selection and sign/zero extension for a DATA_W-wide bus.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]        rdata,
    input  logic [off_w(DATA_W)-1:0] off,
    input  logic [LOAD_OP_W-1:0]     load_op,
    output logic [DATA_W-1:0]        result
);

    localparam int OFF_W = off_w(DATA_W);

    logic [OFF_W+3:0] b_amt;
    logic [OFF_W+3:0] h_amt;
    logic [OFF_W+3:0] w_amt;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    // Halfword and word lanes are the byte shift with the low offset bits cleared.
    always_comb begin
        b_amt  = {1'b0, off, 3'b000};
        h_amt  = b_amt & ~(OFF_W + 4)'(8);
        w_amt  = b_amt & ~(OFF_W + 4)'(24);
        byte_v = 8'(rdata >> b_amt);
        half_v = 16'(rdata >> h_amt);
        word_v = 32'(rdata >> w_amt);
    end

    always_comb begin
        result = '0;
        if (load_op[LD_B])
            result = DATA_W'($signed(byte_v));
        else if (load_op[LD_H])
            result = DATA_W'($signed(half_v));
        else if (load_op[LD_W])
            result = DATA_W'($signed(word_v));
        else if (load_op[LD_BU])
            result = DATA_W'(byte_v);
        else if (load_op[LD_HU])
            result = DATA_W'(half_v);
        else if (load_op[LD_WU] && DATA_W == 64)
            result = DATA_W'(word_v);
        else if (load_op[LD_D] && DATA_W == 64)
            result = rdata;
    end

endmodule

// File: rtl/mem_stage_async.sv
// MEM stage consuming a split-transaction data bus; buffers stalled responses and drops flushed ones.
// Optional MS_PERF_CNT_EN adds the ms_load_stall_cnt output.
module mem_stage_async
    import mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2,
    parameter int ES_BUS_WD = 48 + 2 * DATA_W,
    parameter int WS_BUS_WD = 39 + DATA_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 es_to_ms_valid,
    input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
    output logic                 ms_allowin,
    input  logic                 es_req_pending,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic [WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [DATA_W+6:0]    ms_fwd_bus,
    input  logic                 data_ok,
    input  logic [DATA_W-1:0]    rdata,
    input  logic                 ms_flush_pipe,
`ifdef MS_PERF_CNT_EN
    output logic [31:0]          ms_load_stall_cnt,
`endif
    output logic                 ms_to_es_ex
);

    localparam int OFF_W = off_w(DATA_W);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int SUM_W = CNT_W + 2;

    logic                 ms_valid_q, ms_valid_d;
    logic [ES_BUS_WD-1:0] es_bus_q, es_bus_d;
    logic                 rbuf_vld_q, rbuf_vld_d;
    logic [DATA_W-1:0]    rbuf_q, rbuf_d;
    logic [CNT_W-1:0]     cancel_cnt_q, cancel_cnt_d;

    logic [31:0]          pc;
    logic [DATA_W-1:0]    alu_result;
    logic [4:0]           dest;
    logic                 gr_we, res_from_mem, mem_req, ex;
    logic [LOAD_OP_W-1:0] load_op;
    logic [DATA_W-1:0]    vaddr;

    assign ex           = es_bus_q[es_ex_lsb(DATA_W)];
    assign vaddr        = es_bus_q[es_vaddr_lsb(DATA_W) +: DATA_W];
    assign load_op      = es_bus_q[es_lop_lsb(DATA_W) +: LOAD_OP_W];
    assign mem_req      = es_bus_q[es_mreq_lsb(DATA_W)];
    assign res_from_mem = es_bus_q[es_rfm_lsb(DATA_W)];
    assign gr_we        = es_bus_q[es_grwe_lsb(DATA_W)];
    assign dest         = es_bus_q[es_dest_lsb(DATA_W) +: 5];
    assign alu_result   = es_bus_q[es_alu_lsb(DATA_W) +: DATA_W];
    assign pc           = es_bus_q[es_pc_lsb(DATA_W) +: 32];

    logic unused_vaddr_hi;
    assign unused_vaddr_hi = ^vaddr[DATA_W-1:OFF_W];

    logic owned_ok, resp_here, ms_ready_go, ms_leave, cnt_dec;
    logic [SUM_W-1:0] cnt_inc, cnt_sum;
    logic [DATA_W-1:0] load_src, load_res, final_result;

    // A response is only ours once every response owed to flushed instructions has drained.
    always_comb begin
        owned_ok       = data_ok && (cancel_cnt_q == '0) && ms_valid_q && mem_req && !rbuf_vld_q;
        resp_here      = owned_ok || rbuf_vld_q;
        ms_ready_go    = !mem_req || ex || resp_here;
        ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid_q && ms_ready_go && !ms_flush_pipe;
        ms_leave       = ms_valid_q && ms_ready_go && ws_allowin;
        ms_to_es_ex    = ms_valid_q && ex;
        cnt_dec        = data_ok && (cancel_cnt_q != '0);
    end

    always_comb begin
        ms_valid_d = ms_valid_q;
        es_bus_d   = es_bus_q;
        if (ms_flush_pipe)
            ms_valid_d = 1'b0;
        else if (ms_allowin)
            ms_valid_d = es_to_ms_valid;
        if (es_to_ms_valid && ms_allowin)
            es_bus_d = es_to_ms_bus;
    end

    always_comb begin
        rbuf_vld_d = rbuf_vld_q;
        rbuf_d     = rbuf_q;
        if (ms_flush_pipe || ms_leave) begin
            rbuf_vld_d = 1'b0;
        end else if (owned_ok && !ws_allowin) begin
            rbuf_vld_d = 1'b1;
            rbuf_d     = rdata;
        end
    end

    always_comb begin
        cnt_inc = '0;
        if (ms_flush_pipe)
            cnt_inc = SUM_W'(ms_valid_q && mem_req && !resp_here) + SUM_W'(es_req_pending);
        cnt_sum = SUM_W'(cancel_cnt_q) + cnt_inc - SUM_W'(cnt_dec);
        if (cnt_sum > SUM_W'(MAX_OUTST))
            cancel_cnt_d = CNT_W'(MAX_OUTST);
        else
            cancel_cnt_d = cnt_sum[CNT_W-1:0];
    end

    cancel_cnt_in_range: assert property (@(posedge clk) disable iff (!resetn)
        cnt_sum <= SUM_W'(MAX_OUTST));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q   <= 1'b0;
            rbuf_vld_q   <= 1'b0;
            cancel_cnt_q <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            rbuf_vld_q   <= rbuf_vld_d;
            cancel_cnt_q <= cancel_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        es_bus_q <= es_bus_d;
        rbuf_q   <= rbuf_d;
    end

    assign load_src = rbuf_vld_q ? rbuf_q : rdata;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata   (load_src),
        .off     (vaddr[OFF_W-1:0]),
        .load_op (load_op),
        .result  (load_res)
    );

    assign final_result = res_from_mem ? load_res : alu_result;
    assign ms_to_ws_bus = {pc, ex, gr_we, dest, final_result};
    assign ms_fwd_bus   = {ms_valid_q && res_from_mem && !ms_ready_go,
                           ms_valid_q && gr_we, dest, final_result};

`ifdef MS_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = stall_cnt_q + 32'(ms_valid_q && mem_req && !ms_ready_go);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign ms_load_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_async.sv
// Directed bench for mem_stage_async with a scoreboard of expected WB payloads (32- and 64-bit instances).
module tb_mem_stage_async;

    logic         clk;
    logic         resetn, es_valid, es_req_pending, ws_allowin, data_ok, flush;
    logic [111:0] es_bus;
    logic [31:0]  rdata;
    logic         ms_allowin, ms_to_ws_valid, ms_to_es_ex;
    logic [70:0]  ws_bus;
    logic [38:0]  fwd_bus;

    logic         w_resetn, w_es_valid, w_data_ok, w_allowin, w_to_ws_valid, w_to_es_ex;
    logic         w_zero;
    logic [175:0] w_es_bus;
    logic [63:0]  w_rdata;
    logic [102:0] w_ws_bus;
    logic [70:0]  w_fwd_bus;

`ifdef MS_PERF_CNT_EN
    logic [31:0]  stall_cnt, w_stall_cnt, stall_base;
`endif

    int passed = 0;
    int total  = 0;
    logic [70:0]  q32[$];
    logic [102:0] q64[$];

    mem_stage_async #(.DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .es_to_ms_valid(es_valid), .es_to_ms_bus(es_bus),
        .ms_allowin(ms_allowin), .es_req_pending(es_req_pending), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ws_bus), .ms_fwd_bus(fwd_bus),
        .data_ok(data_ok), .rdata(rdata), .ms_flush_pipe(flush),
`ifdef MS_PERF_CNT_EN
        .ms_load_stall_cnt(stall_cnt),
`endif
        .ms_to_es_ex(ms_to_es_ex)
    );

    mem_stage_async #(.DATA_W(64)) dut64 (
        .clk(clk), .resetn(w_resetn), .es_to_ms_valid(w_es_valid), .es_to_ms_bus(w_es_bus),
        .ms_allowin(w_allowin), .es_req_pending(w_zero), .ws_allowin(1'b1),
        .ms_to_ws_valid(w_to_ws_valid), .ms_to_ws_bus(w_ws_bus), .ms_fwd_bus(w_fwd_bus),
        .data_ok(w_data_ok), .rdata(w_rdata), .ms_flush_pipe(w_zero),
`ifdef MS_PERF_CNT_EN
        .ms_load_stall_cnt(w_stall_cnt),
`endif
        .ms_to_es_ex(w_to_es_ex)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [111:0] es32(input logic [31:0] pc, input logic [31:0] alu,
                                          input logic [4:0] dest, input logic gr_we, input logic rfm,
                                          input logic mreq, input logic [6:0] lop,
                                          input logic [31:0] va, input logic ex);
        return {pc, alu, dest, gr_we, rfm, mreq, lop, va, ex};
    endfunction

    function automatic logic [70:0] ws32(input logic [31:0] pc, input logic ex, input logic gr_we,
                                         input logic [4:0] dest, input logic [31:0] res);
        return {pc, ex, gr_we, dest, res};
    endfunction

    function automatic logic [175:0] es64(input logic [31:0] pc, input logic [4:0] dest,
                                          input logic [6:0] lop, input logic [63:0] va);
        return {pc, 64'h0, dest, 1'b1, 1'b1, 1'b1, lop, va, 1'b0};
    endfunction

    function automatic logic [102:0] ws64(input logic [31:0] pc, input logic [4:0] dest,
                                          input logic [63:0] res);
        return {pc, 1'b0, 1'b1, dest, res};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pop32(input string tag);
        logic [70:0] exp;
        chk({tag, "_vld"}, 128'(ms_to_ws_valid), 128'(1));
        exp = (q32.size() > 0) ? q32.pop_front() : 'x;
        chk(tag, 128'(ws_bus), 128'(exp));
    endtask

    task automatic pop64(input string tag);
        logic [102:0] exp;
        chk({tag, "_vld"}, 128'(w_to_ws_valid), 128'(1));
        exp = (q64.size() > 0) ? q64.pop_front() : 'x;
        chk(tag, 128'(w_ws_bus), 128'(exp));
    endtask

    initial begin
        resetn = 0; es_valid = 0; es_bus = '0; es_req_pending = 0; ws_allowin = 1;
        data_ok = 0; rdata = '0; flush = 0;
        w_resetn = 0; w_es_valid = 0; w_es_bus = '0; w_data_ok = 0; w_rdata = '0; w_zero = 0;

        @(negedge clk); #1;
        chk("rst_allowin", 128'(ms_allowin), 128'(1));
        chk("rst_ws_valid", 128'(ms_to_ws_valid), 128'(0));
        chk("rst_fwd_flags", 128'(fwd_bus[38:37]), 128'(0));
        chk("rst_to_es_ex", 128'(ms_to_es_ex), 128'(0));
        chk("rst64_allowin", 128'(w_allowin), 128'(1));

        // ld.b at offset 3, response three cycles after entry
        @(negedge clk);
        resetn = 1; w_resetn = 1;
        es_valid = 1;
        es_bus = es32(32'h1c00_0000, 32'h0, 5'd5, 1, 1, 1, 7'b0000001, 32'h0000_1003, 0);
        q32.push_back(ws32(32'h1c00_0000, 0, 1, 5'd5, 32'hFFFF_FF80));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); es_valid = 0; #1;
            chk("s1_wait_vld", 128'(ms_to_ws_valid), 128'(0));
            chk("s1_fwd_block", 128'(fwd_bus[38]), 128'(1));
            chk("s1_allowin", 128'(ms_allowin), 128'(0));
        end
        chk("s1_fwd_valid", 128'(fwd_bus[37]), 128'(1));
        @(negedge clk); data_ok = 1; rdata = 32'h80FF_1234; #1;
        pop32("s1_ldb");
        chk("s1_fwd_unblock", 128'(fwd_bus[38]), 128'(0));

        // ld.hu whose response arrives while WB is stalled
        @(negedge clk);
        data_ok = 0; es_valid = 1;
        es_bus = es32(32'h1c00_0010, 32'h0, 5'd6, 1, 1, 1, 7'b0010000, 32'h0000_2000, 0);
        q32.push_back(ws32(32'h1c00_0010, 0, 1, 5'd6, 32'h0000_5A5A));
        #1 chk("s1_left", 128'(ms_to_ws_valid), 128'(0));
        @(negedge clk); es_valid = 0; ws_allowin = 0; data_ok = 1; rdata = 32'h0000_5A5A; #1;
        chk("s2_vld_stalled", 128'(ms_to_ws_valid), 128'(1));
        chk("s2_allowin", 128'(ms_allowin), 128'(0));
        @(negedge clk); data_ok = 0; rdata = 32'hDEAD_BEEF; #1;
        chk("s2_hold_vld", 128'(ms_to_ws_valid), 128'(1));
        chk("s2_rbuf_data", 128'(ws_bus[31:0]), 128'(32'h0000_5A5A));
        @(negedge clk); ws_allowin = 1; #1;
        pop32("s2_ldhu");
        chk("s2_release_allowin", 128'(ms_allowin), 128'(1));

        // flush while waiting with a request pending in EX: two responses must be dropped
        @(negedge clk); es_valid = 1;
        es_bus = es32(32'h1c00_0020, 32'h0, 5'd7, 1, 1, 1, 7'b0000100, 32'h0000_3000, 0);
        @(negedge clk); es_valid = 0; #1;
        chk("s3_rbuf_cleared", 128'(ms_to_ws_valid), 128'(0));
        @(negedge clk); flush = 1; es_req_pending = 1; #1;
        chk("s3_flush_vld", 128'(ms_to_ws_valid), 128'(0));
        @(negedge clk); flush = 0; es_req_pending = 0; es_valid = 1;
        es_bus = es32(32'h1c00_0030, 32'h0, 5'd8, 1, 1, 1, 7'b0000100, 32'h0000_3004, 0);
        q32.push_back(ws32(32'h1c00_0030, 0, 1, 5'd8, 32'h3333_3333));
        #1 chk("s3_allowin", 128'(ms_allowin), 128'(1));
        @(negedge clk); es_valid = 0; data_ok = 1; rdata = 32'h1111_1111; #1;
        chk("s3_drop1", 128'(ms_to_ws_valid), 128'(0));
        @(negedge clk); rdata = 32'h2222_2222; #1;
        chk("s3_drop2", 128'(ms_to_ws_valid), 128'(0));
        @(negedge clk); rdata = 32'h3333_3333; #1;
        pop32("s3_third");

        // ALU op then an excepting instruction: both pass through without waiting
        @(negedge clk); data_ok = 0; es_valid = 1;
        es_bus = es32(32'h1c00_0040, 32'h1234_5678, 5'd9, 1, 0, 0, 7'b0, 32'h0, 0);
        q32.push_back(ws32(32'h1c00_0040, 0, 1, 5'd9, 32'h1234_5678));
        @(negedge clk); es_valid = 1;
        es_bus = es32(32'h1c00_0044, 32'hABCD_0000, 5'd0, 0, 0, 0, 7'b0, 32'h0, 1);
        q32.push_back(ws32(32'h1c00_0044, 1, 0, 5'd0, 32'hABCD_0000));
        #1 pop32("s4_alu");
        chk("s4_fwd_valid", 128'(fwd_bus[37]), 128'(1));
        chk("s4_fwd_block", 128'(fwd_bus[38]), 128'(0));
        chk("s4_fwd_payload", 128'(fwd_bus[36:0]), 128'({5'd9, 32'h1234_5678}));
        @(negedge clk); es_valid = 0; #1;
        pop32("s4_ex");
        chk("s4_to_es_ex", 128'(ms_to_es_ex), 128'(1));

        // store waiting five cycles for its acknowledge
        @(negedge clk); es_valid = 1;
        es_bus = es32(32'h1c00_0048, 32'h0000_0100, 5'd0, 0, 0, 1, 7'b0, 32'h0000_0100, 0);
        q32.push_back(ws32(32'h1c00_0048, 0, 0, 5'd0, 32'h0000_0100));
        #1 chk("s5_ex_gone", 128'(ms_to_es_ex), 128'(0));
`ifdef MS_PERF_CNT_EN
        stall_base = stall_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); es_valid = 0; #1;
            chk("s5_store_wait", 128'(ms_to_ws_valid), 128'(0));
        end
        @(negedge clk); data_ok = 1; rdata = 32'hFFFF_FFFF; #1;
        pop32("s5_store");
`ifdef MS_PERF_CNT_EN
        chk("s5_stall_cnt", 128'(stall_cnt - stall_base), 128'(5));
`endif

        // async reset in the middle of a wait with one response still owed
        @(negedge clk); data_ok = 0; es_valid = 1;
        es_bus = es32(32'h1c00_0050, 32'h0, 5'd10, 1, 1, 1, 7'b0000001, 32'h0000_5000, 0);
        @(negedge clk); es_valid = 0; flush = 1; #1;
        chk("s6_flush_vld", 128'(ms_to_ws_valid), 128'(0));
        @(negedge clk); flush = 0; es_valid = 1;
        es_bus = es32(32'h1c00_0054, 32'h0, 5'd11, 1, 1, 1, 7'b0000100, 32'h0000_5004, 0);
        #1 chk("s6_allowin", 128'(ms_allowin), 128'(1));
        @(negedge clk); es_valid = 0; #1;
        chk("s6_waiting", 128'(ms_allowin), 128'(0));
        #2 resetn = 0; #1;
        chk("s6_rst_allowin", 128'(ms_allowin), 128'(1));
        chk("s6_rst_vld", 128'(ms_to_ws_valid), 128'(0));
        chk("s6_rst_fwd", 128'(fwd_bus[38:37]), 128'(0));
        @(negedge clk); resetn = 1; es_valid = 1;
        es_bus = es32(32'h1c00_0058, 32'h0, 5'd12, 1, 1, 1, 7'b0000100, 32'h0000_5008, 0);
        q32.push_back(ws32(32'h1c00_0058, 0, 1, 5'd12, 32'hCAFE_F00D));
        @(negedge clk); es_valid = 0; data_ok = 1; rdata = 32'hCAFE_F00D; #1;
        pop32("s6_after_rst");

        // ld.wu is not a 32-bit load: result is zero
        @(negedge clk); data_ok = 0; es_valid = 1;
        es_bus = es32(32'h1c00_005c, 32'h0, 5'd13, 1, 1, 1, 7'b0100000, 32'h0000_500c, 0);
        q32.push_back(ws32(32'h1c00_005c, 0, 1, 5'd13, 32'h0));
        @(negedge clk); es_valid = 0; data_ok = 1; rdata = 32'hFFFF_FFFF; #1;
        pop32("s6_wu32_zero");
        @(negedge clk); data_ok = 0;

        // 64-bit data path: ld.wu at offset 4, ld.h at offset 6, ld.d
        w_es_valid = 1;
        w_es_bus = es64(32'h1c00_0060, 5'd13, 7'b0100000, 64'h1004);
        q64.push_back(ws64(32'h1c00_0060, 5'd13, 64'h0000_0000_8765_4321));
        @(negedge clk);
        w_es_bus = es64(32'h1c00_0064, 5'd14, 7'b0000010, 64'h1006);
        q64.push_back(ws64(32'h1c00_0064, 5'd14, 64'hFFFF_FFFF_FFFF_8765));
        w_data_ok = 1; w_rdata = 64'h8765_4321_0000_0000; #1;
        pop64("s7_ldwu");
        @(negedge clk);
        w_es_bus = es64(32'h1c00_0068, 5'd15, 7'b1000000, 64'h1000);
        q64.push_back(ws64(32'h1c00_0068, 5'd15, 64'h0123_4567_89AB_CDEF));
        #1 pop64("s7_ldh");
        @(negedge clk); w_es_valid = 0; w_rdata = 64'h0123_4567_89AB_CDEF; #1;
        pop64("s7_ldd");
        @(negedge clk); w_data_ok = 0; #1;
        chk("s7_idle", 128'(w_to_ws_valid), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage_async.md
Name: mem_stage_async

Overview:
- Parametrised MEM stage for the LoongArch pipeline, sitting between EX and WB.
- Successor to the fixed-latency SRAM MEM stage. It consumes the split-transaction data bus response (data_ok/rdata), so loads may take any number of cycles to return.
- Buffers a response that arrives while WB is stalled.
- Discards responses that belong to flushed instructions.
- Supports 32- or 64-bit data paths.

Parameters:
- DATA_W, 32, data path and GPR result width; legal values 32 or 64.
- MAX_OUTST, 2, maximum bus responses outstanding across EX and MEM; sizes the cancel counter.
- ES_BUS_WD, 48+2*DATA_W, width of es_to_ms_bus (layout in package).
- WS_BUS_WD, 39+DATA_W, width of ms_to_ws_bus.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- es_to_ms_valid  in  1  EX holds a valid instruction for MEM.
- es_to_ms_bus  in  ES_BUS_WD  fields: pc[31:0], alu_result[DATA_W-1:0], dest[4:0], gr_we, res_from_mem, mem_req, load_op[6:0], vaddr[DATA_W-1:0], ex.
- ms_allowin  out  1  MEM can accept an instruction.
- es_req_pending  in  1  EX instruction has an accepted bus request awaiting data_ok.
- ws_allowin  in  1  WB can accept an instruction.
- ms_to_ws_valid  out  1  MEM presents a valid instruction to WB.
- ms_to_ws_bus  out  WS_BUS_WD  fields: pc, ex, gr_we, dest, final_result.
- ms_fwd_bus  out  DATA_W+7  fields: {fwd_block, fwd_valid, dest, final_result}.
- data_ok  in  1  bus read/write response (one per accepted request, in order).
- rdata  in  DATA_W  response data.
- ms_flush_pipe  in  1  exception/ertn flush from WB.
- ms_to_es_ex  out  1  ms_valid && ex; EX suppresses new requests.

Behaviour:
- Reset (async, resetn=0) clears the following state:
  - ms_valid=0, rbuf_vld=0, cancel_cnt=0.
  - Outputs: ms_allowin=1, ms_to_ws_valid=0, fwd_valid=0, fwd_block=0, ms_to_es_ex=0.
  - Payload registers are not reset.
- Stage register:
  - ms_valid loads es_to_ms_valid when ms_allowin.
  - If ms_flush_pipe is high, ms_valid is cleared instead.
  - The bus is captured when es_to_ms_valid && ms_allowin.
- Response ownership:
  - Responses return in order.
  - While cancel_cnt>0, each data_ok is dropped and cancel_cnt decrements.
  - Otherwise data_ok belongs to the MEM instruction if ms_valid && mem_req && !rbuf_vld.
- resp_here = owned data_ok this cycle || rbuf_vld.
- ms_ready_go = !mem_req || ex || resp_here.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush_pipe.
- Response buffer:
  - An owned data_ok in a cycle where the instruction does not leave MEM (ws_allowin=0) sets rbuf_vld and captures rdata.
  - rbuf_vld clears when the instruction leaves MEM, on flush, or on reset.
  - Load data source = rbuf_vld ? rbuf : rdata.
- Flush accounting: on ms_flush_pipe, cancel_cnt gains
  - (ms_valid && mem_req && !resp_here), plus
  - es_req_pending.
- cancel_cnt arithmetic:
  - An increment and a decrement in the same cycle apply their net change.
  - The counter saturates at MAX_OUTST; exceeding it is illegal and asserted in simulation.
  - A new instruction may enter during cancel; its own response is recognised only once cancel_cnt reaches 0.
- Load alignment, with off = vaddr[log2(DATA_W/8)-1:0]:
  - load_op one-hot: bit0 b, bit1 h, bit2 w, bit3 bu, bit4 hu, bit5 wu, bit6 d.
  - Byte lane = off; halfword lane = off>>1; word lane = off>>2.
  - Sign- or zero-extend to DATA_W.
  - wu and d are legal only when DATA_W=64; with DATA_W=32 the result is 0.
  - final_result = res_from_mem ? aligned load : alu_result.
- Forwarding:
  - fwd_valid = ms_valid && gr_we.
  - fwd_block = ms_valid && res_from_mem && !ms_ready_go; ID must stall on a dest match.
- Stores: mem_req=1 with res_from_mem=0. The stage still waits for data_ok; the data is ignored.

Optional Feature:
- Macro: MS_PERF_CNT_EN.
- With the macro defined:
  - Adds output ms_load_stall_cnt [31:0], a free-running wrapping counter.
  - It increments each cycle ms_valid && mem_req && !ms_ready_go.
  - Reset value 0.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mem_pkg holds:
  - load_op bit indices and the LOAD_OP_W=7 constant.
  - Field offsets/widths for es_to_ms_bus and ms_to_ws_bus as functions of DATA_W.
  - Offset width function.
- Sub-module load_align: combinational lane select and extension, parameterised by DATA_W.

Test Plan:
- DATA_W=32, ld.b at vaddr 0x...3, data_ok 3 cycles after entry with rdata=0x80FF_1234 -> ms_ready_go low 3 cycles, fwd_block=1, then final_result=0xFFFF_FF80.
- data_ok with ws_allowin=0 for 2 cycles, rdata=0x0000_5A5A, ld.hu at offset 0 -> rbuf_vld=1; on release the result is 0x5A5A and rbuf clears.
- Flush while MEM waits and es_req_pending=1 -> cancel_cnt=2; the next two data_ok are dropped; a new lw entering gets the third data_ok.
- DATA_W=64, ld.wu at offset 4, rdata=0x8765_4321_0000_0000 -> final_result=0x0000_0000_8765_4321.
- resetn asserted mid-wait with cancel_cnt=1 -> all state is 0 immediately, ms_allowin=1.
- With MS_PERF_CNT_EN, a 5-cycle load wait -> ms_load_stall_cnt increases by 5.
